// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU datapath encodings: opcodes, ALU ops, mux selects, error codes
package cpu_defs_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b010000;
  localparam logic [5:0] OP_ORI  = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b100111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b111000;
  localparam logic [5:0] OP_MOVE = 6'b111001;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // ALU operation for the immediate-form arithmetic instructions
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts wait cycles of an outstanding memory request, flags timeout
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] count;

  // Idle cycles and completed requests clear the count, so every new request starts at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (!req || ready)  count <= '0;
    else                     count <= count + W'(1);
  end

  assign timeout = req && !ready && (count == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle CPU control sequencer with memory handshake and retire counter
module multicycle_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcWrite,
  output logic                 irWrite,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [1:0]           memToReg,
  output logic [1:0]           regDst,
  output logic                 regWrite,
  output logic                 ALUsrcA,
  output logic [1:0]           ALUsrcB,
  output logic [2:0]           ALUop,
  output logic [1:0]           pcSource,
  output logic                 byteOperations,
  output logic                 move,
  output logic                 instr_done,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] retired
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_MOVE, S_ERROR
  } state_t;

  state_t     state;
  logic [5:0] op_q;
  logic       mem_req;
  logic       timeout;

  assign mem_req = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      err_code <= ERR_NONE;
      retired  <= '0;
    end else begin
      if (instr_done) retired <= retired + CNT_WIDTH'(1);
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
          else if (timeout) begin
            state    <= S_ERROR;
            err_code <= ERR_TIMEOUT;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state <= S_EXEC;
            OP_LW, OP_LB, OP_SW, OP_SB:              state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                          state <= S_BRANCH;
            OP_J, OP_JAL:                            state <= S_JUMP;
            OP_MOVE:                                 state <= S_MOVE;
            default: begin
              state    <= S_ERROR;
              err_code <= ERR_ILLEGAL;
            end
          endcase
        end
        S_EXEC:     state <= S_WB_ALU;
        S_MEM_ADDR: state <= (op_q == OP_LW || op_q == OP_LB) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) state <= (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          else if (timeout) begin
            state    <= S_ERROR;
            err_code <= ERR_TIMEOUT;
          end
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_MOVE: state <= S_FETCH;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state and latched opcode; only the memory/branch strobes see live inputs
  always_comb begin
    pcWrite = 1'b0;  irWrite = 1'b0;  iorD = 1'b0;  memRead = 1'b0;  memWrite = 1'b0;
    memToReg = M2R_ALUOUT;  regDst = DST_RT;  regWrite = 1'b0;  ALUsrcA = 1'b0;
    ALUsrcB = SRCB_REG;  ALUop = ALU_FUNCT;  pcSource = PCS_ALU;
    byteOperations = 1'b0;  move = 1'b0;  instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        memRead = 1'b1;  ALUsrcB = SRCB_FOUR;  ALUop = ALU_ADD;
        irWrite = mem_ready;  pcWrite = mem_ready;
      end
      S_DECODE: begin
        ALUsrcB = SRCB_IMM_SH;  ALUop = ALU_ADD;
      end
      S_EXEC: begin
        ALUsrcA = 1'b1;
        if (op_q == OP_R) begin
          ALUsrcB = SRCB_REG;  ALUop = ALU_FUNCT;
        end else begin
          ALUsrcB = SRCB_IMM;  ALUop = imm_aluop(op_q);
        end
      end
      S_WB_ALU: begin
        regWrite = 1'b1;  instr_done = 1'b1;
        regDst = (op_q == OP_R) ? DST_RD : DST_RT;
      end
      S_MEM_ADDR: begin
        ALUsrcA = 1'b1;  ALUsrcB = SRCB_IMM;  ALUop = ALU_ADD;
      end
      S_MEM_RD: begin
        iorD = 1'b1;  memRead = 1'b1;  byteOperations = (op_q == OP_LB);
      end
      S_MEM_WR: begin
        iorD = 1'b1;  memWrite = 1'b1;  byteOperations = (op_q == OP_SB);
        instr_done = mem_ready;
      end
      S_WB_MEM: begin
        regWrite = 1'b1;  memToReg = M2R_MDR;  byteOperations = (op_q == OP_LB);
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA = 1'b1;  ALUsrcB = SRCB_REG;  ALUop = ALU_SUB;  pcSource = PCS_ALUOUT;
        pcWrite = (op_q == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcWrite = 1'b1;  pcSource = PCS_JUMP;  instr_done = 1'b1;
        if (op_q == OP_JAL) begin
          regWrite = 1'b1;  regDst = DST_RA;  memToReg = M2R_PC;
        end
      end
      S_MOVE: begin
        regWrite = 1'b1;  move = 1'b1;  instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
